// File: rtl/speck_pkg.sv
// Shared constants, FSM state type and 16-bit rotate helpers for the SPECK32/64 cores.
package speck_pkg;

  localparam int SPECK_WORD_W = 16;
  localparam int SPECK_ROUNDS = 22;
  localparam int SPECK_ALPHA  = 7;
  localparam int SPECK_BETA   = 2;

  typedef logic [SPECK_WORD_W-1:0] speck_word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DECRYPT,
    ST_DONE
  } speck_state_t;

  function automatic speck_word_t rol16(input speck_word_t v, input int unsigned n);
    return (v << n) | (v >> (SPECK_WORD_W - n));
  endfunction

  function automatic speck_word_t ror16(input speck_word_t v, input int unsigned n);
    return (v >> n) | (v << (SPECK_WORD_W - n));
  endfunction

endpackage

// File: rtl/speck_dec_round.sv
// One combinational SPECK32/64 inverse round: undoes the y mix first, then the x mix.
module speck_dec_round
  import speck_pkg::*;
(
  input  logic [SPECK_WORD_W-1:0] x,
  input  logic [SPECK_WORD_W-1:0] y,
  input  logic [SPECK_WORD_W-1:0] k,
  output logic [SPECK_WORD_W-1:0] x_next,
  output logic [SPECK_WORD_W-1:0] y_next
);

  speck_word_t x_sub;

  always_comb begin
    y_next = ror16(y ^ x, SPECK_BETA);
    x_sub  = (x ^ k) - y_next;
    x_next = rol16(x_sub, SPECK_ALPHA);
  end

endmodule

// File: rtl/speck32_decrypt.sv
// Iterative SPECK32/64 decryption: expand the key into a 22-entry store, then run 22 inverse rounds.
// Optional macro SPECK_KEY_CACHE_EN skips expansion when the key matches the last expanded key.
module speck32_decrypt
  import speck_pkg::*;
#(
  parameter int ROUNDS = SPECK_ROUNDS
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_ct,
  input  logic [63:0] s_key,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_pt
);

  localparam int CNT_W = $clog2(ROUNDS);
  localparam logic [CNT_W-1:0] LAST_EXPAND = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] LAST_ROUND  = CNT_W'(ROUNDS - 1);

  speck_state_t     state_reg, state_next;
  speck_word_t      x_reg, y_reg, k_reg, rk_fwd_reg, rk_ram_reg;
  speck_word_t      l_reg [3];
  logic [CNT_W-1:0] cnt_reg;
  logic             fwd_sel_reg;
  speck_word_t      store [ROUNDS];

  logic             accept, cache_hit, store_we;
  logic [CNT_W-1:0] store_waddr, store_raddr;
  speck_word_t      store_wdata, l_new, k_new, rk, x_dec, y_dec;

  assign accept = s_valid && s_ready && !rst;
  assign m_pt   = {x_reg, y_reg};

`ifdef SPECK_KEY_CACHE_EN
  logic [63:0] key_cache_reg;
  logic        cache_valid_reg;

  assign cache_hit = cache_valid_reg && (s_key == key_cache_reg);

  // The store is overwritten as soon as a new key starts expanding, so the cache drops out until it finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cache_reg   <= '0;
      cache_valid_reg <= 1'b0;
    end else if (accept && !cache_hit) begin
      key_cache_reg   <= s_key;
      cache_valid_reg <= 1'b0;
    end else if (state_reg == ST_EXPAND && cnt_reg == LAST_EXPAND) begin
      cache_valid_reg <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) state_next = cache_hit ? ST_DECRYPT : ST_EXPAND;
      end
      ST_EXPAND:  if (cnt_reg == LAST_EXPAND) state_next = ST_DECRYPT;
      ST_DECRYPT: if (cnt_reg == '0) state_next = ST_DONE;
      ST_DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Key schedule step i: the l words form a 3-deep shift register feeding back l_new.
  always_comb begin
    l_new = (k_reg + ror16(l_reg[0], SPECK_ALPHA)) ^ SPECK_WORD_W'(cnt_reg);
    k_new = rol16(k_reg, SPECK_BETA) ^ l_new;
  end

  always_comb begin
    store_we    = accept || (state_reg == ST_EXPAND);
    store_waddr = accept ? '0 : cnt_reg + 1'b1;
    store_wdata = accept ? s_key[15:0] : k_new;
    store_raddr = '0;
    if (accept)                                         store_raddr = LAST_ROUND;
    else if (state_reg == ST_DECRYPT && cnt_reg != '0)  store_raddr = cnt_reg - 1'b1;
  end

  // Round keys are prefetched one cycle ahead; store[21] is forwarded since it is written on the same edge.
  always_ff @(posedge clk) begin
    if (store_we) store[store_waddr] <= store_wdata;
    rk_ram_reg <= store[store_raddr];
  end

  assign rk = fwd_sel_reg ? rk_fwd_reg : rk_ram_reg;

  speck_dec_round u_round (
    .x      (x_reg),
    .y      (y_reg),
    .k      (rk),
    .x_next (x_dec),
    .y_next (y_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg       <= '0;
      y_reg       <= '0;
      k_reg       <= '0;
      l_reg[0]    <= '0;
      l_reg[1]    <= '0;
      l_reg[2]    <= '0;
      cnt_reg     <= '0;
      fwd_sel_reg <= 1'b0;
      rk_fwd_reg  <= '0;
    end else begin
      fwd_sel_reg <= (state_reg == ST_EXPAND) && (cnt_reg == LAST_EXPAND);
      rk_fwd_reg  <= k_new;
      case (state_reg)
        ST_IDLE: if (accept) begin
          x_reg    <= s_ct[31:16];
          y_reg    <= s_ct[15:0];
          k_reg    <= s_key[15:0];
          l_reg[0] <= s_key[31:16];
          l_reg[1] <= s_key[47:32];
          l_reg[2] <= s_key[63:48];
          cnt_reg  <= cache_hit ? LAST_ROUND : '0;
        end
        ST_EXPAND: begin
          l_reg[0] <= l_reg[1];
          l_reg[1] <= l_reg[2];
          l_reg[2] <= l_new;
          k_reg    <= k_new;
          cnt_reg  <= cnt_reg + 1'b1;
        end
        ST_DECRYPT: begin
          x_reg <= x_dec;
          y_reg <= y_dec;
          if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speck32_decrypt.sv
// Scoreboard bench for speck32_decrypt: reference SPECK32/64 model, latency and handshake checks.
module tb_speck32_decrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_ct = '0;
  logic [63:0] s_key = '0;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_pt;

`ifdef SPECK_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  speck32_decrypt dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_ct    (s_ct),
    .s_key   (s_key),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_pt    (m_pt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pt;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  logic [63:0] cache_key_m = '0;
  bit          cache_v_m = 1'b0;
  int          ready_mode = 0;  // 0 high, 1 random, 2 held low

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the textbook key schedule and round equations.
  function automatic int ror_m(input int v, input int n);
    int w;
    w = v & 'hffff;
    return ((w >> n) | (w << (16 - n))) & 'hffff;
  endfunction

  function automatic int rol_m(input int v, input int n);
    return ror_m(v, 16 - n);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] blk, input logic [63:0] key, input bit enc);
    int k[22];
    int l[24];
    int x, y;
    k[0] = int'(key[15:0]);
    l[0] = int'(key[31:16]);
    l[1] = int'(key[47:32]);
    l[2] = int'(key[63:48]);
    for (int i = 0; i < 21; i++) begin
      l[i+3] = ((k[i] + ror_m(l[i], 7)) & 'hffff) ^ i;
      k[i+1] = rol_m(k[i], 2) ^ l[i+3];
    end
    x = int'(blk[31:16]);
    y = int'(blk[15:0]);
    if (enc) begin
      for (int i = 0; i < 22; i++) begin
        x = ((ror_m(x, 7) + y) & 'hffff) ^ k[i];
        y = rol_m(y, 2) ^ x;
      end
    end else begin
      for (int i = 21; i >= 0; i--) begin
        y = ror_m(y ^ x, 2);
        x = rol_m(((x ^ k[i]) - y) & 'hffff, 7);
      end
    end
    return {x[15:0], y[15:0]};
  endfunction

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0)      m_ready = 1'b1;
    else if (ready_mode == 1) m_ready = 1'($urandom_range(0, 1));
    else                      m_ready = 1'b0;
  end

  // Monitor: samples on the falling edge, pops the scoreboard on every output handshake.
  initial begin
    bit          hold_prev = 1'b0;
    bit          hs_prev = 1'b0;
    bit          valid_prev = 1'b0;
    logic [31:0] hold_pt = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0; hs_prev = 1'b0; valid_prev = 1'b0;
        continue;
      end
      if (hs_prev) chk("s_ready_after_handshake", 64'(s_ready), 64'd1);
      if (hold_prev) begin
        chk("bp_valid_hold", 64'(m_valid), 64'd1);
        chk("bp_pt_hold", 64'(m_pt), 64'(hold_pt));
      end
      if (m_valid) chk("s_ready_busy", 64'(s_ready), 64'd0);
      if (m_valid && !valid_prev) begin
        if (sb.size() == 0) chk("unexpected_output", 64'(m_pt), 64'hx);
        else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      hs_prev = 1'b0;
      hold_prev = 1'b0;
      if (m_valid && m_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("plaintext", 64'(m_pt), 64'(e.pt));
          $display("txn acc=%0d out=%0d pt=%h exp=%h", e.acc, cyc, m_pt, e.pt);
        end
        hs_prev = 1'b1;
      end else if (m_valid) begin
        hold_prev = 1'b1;
        hold_pt = m_pt;
      end
      valid_prev = m_valid;
    end
  end

  // All callers sit 1 time unit after a rising edge.
  task automatic send(input logic [31:0] ct, input logic [63:0] key, input logic [31:0] pt_exp, output int acc);
    int  n = 0;
    bit  hit;
    while (!s_ready && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!s_ready) begin
      chk("s_ready_timeout", 64'(s_ready), 64'd1);
      acc = -1;
      return;
    end
    s_ct = ct; s_key = key; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    acc = cyc;
    hit = CACHE && cache_v_m && (key == cache_key_m);
    if (!hit) begin
      cache_key_m = key;
      cache_v_m = 1'b1;
    end
    sb.push_back('{pt_exp, hit ? 22 : 43, acc});
    s_ct = $urandom;
    s_key = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !s_ready) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] vkey, key, rkey;
    logic [31:0] pt, ct;
    int          acc, n;
    vkey = 64'h1918_1110_0908_0100;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_s_ready", 64'(s_ready), 64'd1);
    chk("reset_m_valid", 64'(m_valid), 64'd0);
    chk("reset_m_pt", 64'(m_pt), 64'd0);

    send(32'ha868_42f2, vkey, 32'h6574_694c, acc);
    send(32'ha868_42f2, vkey, 32'h6574_694c, acc);
    drain();

    ready_mode = 2;
    send(32'ha868_42f2, vkey, 32'h6574_694c, acc);
    n = 0;
    while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("bp_valid_seen", 64'(m_valid), 64'd1);
    repeat (10) @(posedge clk);
    #1 ready_mode = 0;
    drain();

    key = {$urandom, $urandom};
    pt = $urandom;
    send(model(pt, key, 1'b1), key, pt, acc);
    while (cyc < acc + 29) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    cache_v_m = 1'b0;
    chk("midreset_m_valid", 64'(m_valid), 64'd0);
    chk("midreset_s_ready", 64'(s_ready), 64'd1);
    send(model(pt, key, 1'b1), key, pt, acc);
    drain();

    s_valid = 1'b1; rst = 1'b1; s_ct = 32'h1234_5678; s_key = vkey;
    @(posedge clk); #1;
    s_valid = 1'b0; rst = 1'b0;
    cache_v_m = 1'b0;
    chk("reset_beats_valid", 64'(s_ready), 64'd1);

    send(32'h0, 64'h0, model(32'h0, 64'h0, 1'b0), acc);
    drain();

    ready_mode = 1;
    rkey = {$urandom, $urandom};
    for (int t = 0; t < 1000; t++) begin
      if ($urandom_range(0, 3) != 0) rkey = {$urandom, $urandom};
      pt = $urandom;
      ct = model(pt, rkey, 1'b1);
      send(ct, rkey, pt, acc);
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
